// File: rtl/countdown_mod_n.sv
// Modulo-MODULUS down counter: counts MODULUS-1 .. 0, then either wraps or parks
// in EXPIRED (AUTO_RELOAD), with clamped synchronous load and a cascade borrow pulse.
module countdown_mod_n #(
   parameter int MODULUS     = 7,
   parameter int WIDTH       = 3,
   parameter bit AUTO_RELOAD = 1'b1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] value,
   output logic             borrow,
   output logic             zero,
   output logic             expired,
   output logic             load_err
);

   localparam logic [WIDTH-1:0] MAX_VALUE = WIDTH'(MODULUS - 1);
   // One extra bit so MODULUS == 2**WIDTH is representable and every load is in range.
   localparam logic [WIDTH:0]   MOD_EXT   = (WIDTH + 1)'(MODULUS);

   typedef enum logic {
      ST_COUNT   = 1'b0,
      ST_EXPIRED = 1'b1
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_value;
   logic             r_borrow;
   logic             r_load_err;

   logic             w_load_ok;
   logic             w_at_zero;

   assign w_load_ok = ({1'b0, load_value} < MOD_EXT);
   assign w_at_zero = (r_value == '0);

   // NOTE: state registers use non-blocking assignments so every register samples
   // the pre-edge values; the pulses default low and are only raised on their event.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state    <= ST_COUNT;
         r_value    <= MAX_VALUE;
         r_borrow   <= 1'b0;
         r_load_err <= 1'b0;
      end else begin
         r_borrow   <= 1'b0;
         r_load_err <= 1'b0;
         if (load) begin
            r_state <= ST_COUNT;
            if (w_load_ok) begin
               r_value <= load_value;
            end else begin
               r_value    <= MAX_VALUE;
               r_load_err <= 1'b1;
            end
         end else if (enable && (r_state == ST_COUNT)) begin
            if (!w_at_zero) begin
               r_value <= r_value - 1'b1;
            end else begin
               r_borrow <= 1'b1;
               if (AUTO_RELOAD) begin
                  r_value <= MAX_VALUE;
               end else begin
                  r_state <= ST_EXPIRED;
               end
            end
         end
      end
   end

   assign value    = r_value;
   assign borrow   = r_borrow;
   assign zero     = w_at_zero;
   assign expired  = (r_state == ST_EXPIRED);
   assign load_err = r_load_err;

endmodule

// File: tb/tb_countdown_mod_n.sv
// Bench for countdown_mod_n: one auto-reload instance (A) and one stop-at-zero
// instance (B), both MODULUS=7, compared against a plain arithmetic model.
module tb_countdown_mod_n;

   localparam int MOD = 7;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       a_enable = 1'b0, a_load = 1'b0;
   logic [2:0] a_load_value = '0;
   logic       b_enable = 1'b0, b_load = 1'b0;
   logic [2:0] b_load_value = '0;

   logic [2:0] a_value, b_value;
   logic       a_borrow, a_zero, a_expired, a_load_err;
   logic       b_borrow, b_zero, b_expired, b_load_err;
   logic [6:0] a_obs, b_obs;

   int total = 0;
   int bad   = 0;

   // Model state, index 0 = A (auto-reload), index 1 = B (stop at zero)
   int m_val  [2];
   bit m_exp  [2];
   bit m_bor  [2];
   bit m_lerr [2];

   always #5 clock = ~clock;

   countdown_mod_n #(.MODULUS(MOD), .WIDTH(3), .AUTO_RELOAD(1'b1)) u_a (
      .clock(clock), .reset(reset), .enable(a_enable), .load(a_load),
      .load_value(a_load_value), .value(a_value), .borrow(a_borrow),
      .zero(a_zero), .expired(a_expired), .load_err(a_load_err)
   );

   countdown_mod_n #(.MODULUS(MOD), .WIDTH(3), .AUTO_RELOAD(1'b0)) u_b (
      .clock(clock), .reset(reset), .enable(b_enable), .load(b_load),
      .load_value(b_load_value), .value(b_value), .borrow(b_borrow),
      .zero(b_zero), .expired(b_expired), .load_err(b_load_err)
   );

   assign a_obs = {a_value, a_borrow, a_zero, a_expired, a_load_err};
   assign b_obs = {b_value, b_borrow, b_zero, b_expired, b_load_err};

   function automatic logic [6:0] exp_vec(int k);
      logic [2:0] v;
      v = 3'(m_val[k]);
      return {v, m_bor[k], (m_val[k] == 0), m_exp[k], m_lerr[k]};
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_val[k] = MOD - 1; m_exp[k] = 0; m_bor[k] = 0; m_lerr[k] = 0;
      end
   endtask

   task automatic model_edge(int k, bit auto_reload, bit en, bit ld, int lv);
      m_bor[k]  = 0;
      m_lerr[k] = 0;
      if (ld) begin
         m_exp[k] = 0;
         if (lv < MOD) m_val[k] = lv;
         else begin m_val[k] = MOD - 1; m_lerr[k] = 1; end
      end else if (en && !m_exp[k]) begin
         if (m_val[k] == 0) begin
            m_bor[k] = 1;
            if (auto_reload) m_val[k] = MOD - 1;
            else m_exp[k] = 1;
         end else begin
            m_val[k] = m_val[k] - 1;
         end
      end
   endtask

   // Called at a falling edge: drive, let one rising edge pass, return at the next falling edge.
   task automatic tick(bit ae, bit al, int alv, bit be, bit bl, int blv);
      a_enable = ae; a_load = al; a_load_value = 3'(alv);
      b_enable = be; b_load = bl; b_load_value = 3'(blv);
      @(posedge clock);
      model_edge(0, 1'b1, ae, al, alv);
      model_edge(1, 1'b0, be, bl, blv);
      @(negedge clock);
      a_enable = 0; a_load = 0; b_enable = 0; b_load = 0;
   endtask

   task automatic test_reset();
      model_reset();
      repeat (2) @(negedge clock);
      total++;
      if (a_obs !== exp_vec(0)) begin
         bad++; $display("FAIL reset_a: got %b want %b", a_obs, exp_vec(0));
      end
      total++;
      if (b_obs !== exp_vec(1)) begin
         bad++; $display("FAIL reset_b: got %b want %b", b_obs, exp_vec(1));
      end
      reset = 1'b0;
   endtask

   task automatic test_wrap();
      logic [2:0] seq [9] = '{5, 4, 3, 2, 1, 0, 6, 5, 4};
      for (int i = 0; i < 9; i++) begin
         tick(1, 0, 0, 0, 0, 0);
         total++;
         if (a_obs !== exp_vec(0) || a_value !== seq[i]) begin
            bad++; $display("FAIL wrap step %0d: got %b want %b (value %0d)", i, a_obs, exp_vec(0), seq[i]);
         end
      end
   endtask

   task automatic test_async_reset();
      tick(0, 1, 3, 0, 0, 0);
      total++;
      if (a_value !== 3'd3) begin
         bad++; $display("FAIL preload3: got %0d want 3", a_value);
      end
      #1 reset = 1'b1;
      #1;
      model_reset();
      total++;
      if (a_obs !== exp_vec(0)) begin
         bad++; $display("FAIL async_reset: got %b want %b", a_obs, exp_vec(0));
      end
      #1 reset = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_load_priority();
      logic [2:0] seq [3] = '{2, 1, 0};
      for (int i = 0; i < 3; i++) begin
         tick(1, (i == 0), 2, 0, 0, 0);
         total++;
         if (a_obs !== exp_vec(0) || a_value !== seq[i]) begin
            bad++; $display("FAIL load_priority step %0d: got %b want %b", i, a_obs, exp_vec(0));
         end
      end
   endtask

   task automatic test_load_clamp();
      tick(0, 1, 7, 0, 1, 7);
      total++;
      if (a_obs !== exp_vec(0) || a_load_err !== 1'b1 || a_value !== 3'd6) begin
         bad++; $display("FAIL clamp_a: got %b want %b", a_obs, exp_vec(0));
      end
      total++;
      if (b_obs !== exp_vec(1) || b_load_err !== 1'b1) begin
         bad++; $display("FAIL clamp_b: got %b want %b", b_obs, exp_vec(1));
      end
      tick(0, 0, 0, 0, 0, 0);
      total++;
      if (a_load_err !== 1'b0 || b_load_err !== 1'b0 || a_obs !== exp_vec(0)) begin
         bad++; $display("FAIL clamp_pulse: got a=%b b=%b want 0", a_load_err, b_load_err);
      end
   endtask

   task automatic test_expire();
      // load 1, three enables, two extra enables, then load 4
      bit en_s [7] = '{0, 1, 1, 1, 1, 1, 0};
      bit ld_s [7] = '{1, 0, 0, 0, 0, 0, 1};
      int lv_s [7] = '{1, 0, 0, 0, 0, 0, 4};
      for (int i = 0; i < 7; i++) begin
         tick(0, 0, 0, en_s[i], ld_s[i], lv_s[i]);
         total++;
         if (b_obs !== exp_vec(1)) begin
            bad++; $display("FAIL expire step %0d: got %b want %b", i, b_obs, exp_vec(1));
         end
      end
      total++;
      if (b_value !== 3'd4 || b_expired !== 1'b0) begin
         bad++; $display("FAIL expire_exit: got value %0d expired %b want 4 0", b_value, b_expired);
      end
   endtask

   task automatic test_toggle();
      logic [2:0] seq [4] = '{5, 5, 4, 4};
      tick(0, 1, 6, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         tick((i % 2) == 0, 0, 0, 0, 0, 0);
         total++;
         if (a_obs !== exp_vec(0) || a_value !== seq[i] || a_borrow !== 1'b0) begin
            bad++; $display("FAIL toggle step %0d: got %b want %b", i, a_obs, exp_vec(0));
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         tick($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 7),
              $urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0, $urandom_range(0, 7));
         total++;
         if (a_obs !== exp_vec(0)) begin
            bad++; $display("FAIL random_a step %0d: got %b want %b", i, a_obs, exp_vec(0));
         end
         total++;
         if (b_obs !== exp_vec(1)) begin
            bad++; $display("FAIL random_b step %0d: got %b want %b", i, b_obs, exp_vec(1));
         end
      end
   endtask

   initial begin
      test_reset();
      test_wrap();
      test_async_reset();
      test_load_priority();
      test_load_clamp();
      test_expire();
      test_toggle();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
